// File: rtl/mag_stats_tracker.sv
// Conditions a magnitude sample stream: sliding-window average, peak hold with decay, hysteretic alarm.
// Latency: one cycle from an accepted sample (mag_valid=1, clear=0) to updated outputs and the out_valid pulse.
// Backpressure: none; every strobed sample is consumed, and idle cycles only drop the one-cycle pulses.
module mag_stats_tracker #(
  parameter int WIDTH        = 8,
  parameter int AVG_LOG2     = 3,
  parameter int HOLD_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mag_valid,
  input  logic [WIDTH-1:0] mag_in,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic [WIDTH-1:0] peak_out,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             out_valid
);

  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW  = WIDTH + AVG_LOG2;
  localparam int HW  = $clog2(HOLD_SAMPLES + 1);
  localparam logic [AVG_LOG2:0] FILL_FULL = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [HW-1:0]     HOLD_LIM  = HW'(HOLD_SAMPLES);

  typedef enum logic {BELOW = 1'b0, ABOVE = 1'b1} state_t;

  logic [WIDTH-1:0]    win_buf_q [WIN];
  logic [WIDTH-1:0]    win_buf_d [WIN];
  logic [AVG_LOG2-1:0] wp_q, wp_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [WIDTH-1:0]    avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic [WIDTH-1:0]    peak_q, peak_d;
  state_t              state_q, state_d;
  logic                alarm_rise_q, alarm_rise_d;
  logic                out_valid_q, out_valid_d;

  logic [SW-1:0]       sum_next;
  logic [WIDTH-1:0]    avg_next;

  // Next-state logic: clear wins over a strobe; otherwise an accepted sample updates everything at once.
  always_comb begin
    win_buf_d    = win_buf_q;
    wp_d         = wp_q;
    sum_d        = sum_q;
    fill_d       = fill_q;
    hold_d       = hold_q;
    avg_d        = avg_q;
    avg_valid_d  = avg_valid_q;
    peak_d       = peak_q;
    state_d      = state_q;
    alarm_rise_d = 1'b0;
    out_valid_d  = 1'b0;
    // The oldest slot leaves as the new sample enters; the sum always covers exactly WIN slots,
    // so it cannot exceed WIN * max(sample) and intermediate wrap cancels out.
    sum_next = sum_q + SW'(mag_in) - SW'(win_buf_q[wp_q]);
    avg_next = sum_next[SW-1:AVG_LOG2];

    if (clear) begin
      for (int i = 0; i < WIN; i++) win_buf_d[i] = '0;
      wp_d        = '0;
      sum_d       = '0;
      fill_d      = '0;
      hold_d      = '0;
      avg_d       = '0;
      avg_valid_d = 1'b0;
      peak_d      = '0;
      state_d     = BELOW;
    end else if (mag_valid) begin
      win_buf_d[wp_q] = mag_in;
      wp_d            = wp_q + AVG_LOG2'(1);
      sum_d           = sum_next;
      avg_d           = avg_next;
      out_valid_d     = 1'b1;
      if (fill_q != FILL_FULL) fill_d = fill_q + (AVG_LOG2 + 1)'(1);
      avg_valid_d = (fill_d == FILL_FULL);

      // Peak: new max restarts the hold; otherwise hold, then decay one step per sample.
      // Decay never undershoots mag_in because mag_in < peak here.
      if (mag_in >= peak_q) begin
        peak_d = mag_in;
        hold_d = '0;
      end else if (hold_q < HOLD_LIM) begin
        hold_d = hold_q + HW'(1);
      end else begin
        peak_d = peak_q - WIDTH'(1);
      end

      // Alarm only judges a full window so a diluted start-up average cannot trip or clear it.
      if (fill_d == FILL_FULL) begin
        case (state_q)
          BELOW: if (avg_next >= thr_hi) begin
            state_d      = ABOVE;
            alarm_rise_d = 1'b1;
          end
          ABOVE: if (avg_next < thr_lo) state_d = BELOW;
          default: state_d = BELOW;
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) win_buf_q[i] <= '0;
      wp_q         <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
      hold_q       <= '0;
      avg_q        <= '0;
      avg_valid_q  <= 1'b0;
      peak_q       <= '0;
      state_q      <= BELOW;
      alarm_rise_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      win_buf_q    <= win_buf_d;
      wp_q         <= wp_d;
      sum_q        <= sum_d;
      fill_q       <= fill_d;
      hold_q       <= hold_d;
      avg_q        <= avg_d;
      avg_valid_q  <= avg_valid_d;
      peak_q       <= peak_d;
      state_q      <= state_d;
      alarm_rise_q <= alarm_rise_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign avg_out    = avg_q;
  assign avg_valid  = avg_valid_q;
  assign peak_out   = peak_q;
  assign alarm      = (state_q == ABOVE);
  assign alarm_rise = alarm_rise_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_mag_stats_tracker.sv
// Bench for mag_stats_tracker: directed scenarios plus randomized traffic against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time unit after the edge.
// Model keeps the accepted samples in a queue and recomputes the average from scratch each time.
module tb_mag_stats_tracker;
  localparam int WIDTH = 8;
  localparam int AVG_LOG2 = 3;
  localparam int HOLD = 4;
  localparam int WIN = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             mag_valid = 1'b0;
  logic [WIDTH-1:0] mag_in = '0;
  logic [WIDTH-1:0] thr_hi = 8'hff;
  logic [WIDTH-1:0] thr_lo = 8'h00;
  logic [WIDTH-1:0] avg_out;
  logic             avg_valid;
  logic [WIDTH-1:0] peak_out;
  logic             alarm;
  logic             alarm_rise;
  logic             out_valid;

  mag_stats_tracker #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .HOLD_SAMPLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mag_valid(mag_valid), .mag_in(mag_in),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .avg_out(avg_out), .avg_valid(avg_valid),
    .peak_out(peak_out), .alarm(alarm), .alarm_rise(alarm_rise), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state.
  int win_q[$];
  int m_avg, m_peak, m_hold;
  bit m_av, m_alarm, m_rise, m_ov;

  function automatic void model_reset();
    win_q.delete();
    m_avg = 0; m_peak = 0; m_hold = 0;
    m_av = 0; m_alarm = 0; m_rise = 0; m_ov = 0;
  endfunction

  function automatic void model_accept(int mag);
    int sum;
    win_q.push_back(mag);
    if (win_q.size() > WIN) void'(win_q.pop_front());
    sum = 0;
    foreach (win_q[i]) sum += win_q[i];
    m_avg = sum / WIN;
    m_av  = (win_q.size() == WIN);
    if (mag >= m_peak) begin
      m_peak = mag; m_hold = 0;
    end else if (m_hold < HOLD) begin
      m_hold++;
    end else begin
      m_peak--;
    end
    m_rise = 0;
    if (win_q.size() == WIN) begin
      if (!m_alarm && m_avg >= int'(thr_hi)) begin
        m_alarm = 1; m_rise = 1;
      end else if (m_alarm && m_avg < int'(thr_lo)) begin
        m_alarm = 0;
      end
    end
    m_ov = 1;
  endfunction

  // One clock of stimulus; the model follows the same edge.
  task automatic step(input bit v, input int m, input bit clr);
    mag_valid = v;
    mag_in    = WIDTH'(m);
    clear     = clr;
    @(posedge clk);
    if (clr) model_reset();
    else if (v) model_accept(m);
    else begin m_ov = 0; m_rise = 0; end
    #1;
    mag_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got avg=%0d av=%0b peak=%0d alarm=%0b rise=%0b ov=%0b, want all 0",
               avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < WIN; i++) begin
      step(1, 40, 0);
      n_checks++;
      if (avg_out !== WIDTH'(5 * (i + 1)) || avg_valid !== (i == WIN - 1) || out_valid !== 1'b1 ||
          peak_out !== 8'd40) begin
        n_fail++;
        $display("FAIL fill_%0d: got avg=%0d av=%0b ov=%0b peak=%0d, want avg=%0d av=%0b ov=1 peak=40",
                 i, avg_out, avg_valid, out_valid, peak_out, 5 * (i + 1), i == WIN - 1);
      end
    end
    step(0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b0 || avg_out !== 8'd40 || avg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_idle: got ov=%0b avg=%0d av=%0b, want ov=0 avg=40 av=1", out_valid, avg_out, avg_valid);
    end
  endtask

  task automatic test_alarm();
    int rises;
    thr_hi = 8'd50;
    thr_lo = 8'd30;
    rises = 0;
    // Sums 340..480: averages 42,45,47,50,52,55,57,60.
    for (int i = 0; i < WIN; i++) begin
      step(1, 60, 0);
      if (alarm_rise === 1'b1) rises++;
      n_checks++;
      if (avg_out !== WIDTH'((320 + 20 * (i + 1)) / 8) || alarm !== m_alarm || alarm_rise !== m_rise) begin
        n_fail++;
        $display("FAIL alarm_up_%0d: got avg=%0d alarm=%0b rise=%0b, want avg=%0d alarm=%0b rise=%0b",
                 i, avg_out, alarm, alarm_rise, (320 + 20 * (i + 1)) / 8, m_alarm, m_rise);
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL alarm_rise_count: got %0d pulses, want 1", rises);
    end
    for (int i = 0; i < WIN; i++) begin
      step(1, 35, 0);
      n_checks++;
      if (alarm !== 1'b1 || alarm_rise !== 1'b0 || avg_out !== WIDTH'(m_avg)) begin
        n_fail++;
        $display("FAIL alarm_hold_%0d: got alarm=%0b rise=%0b avg=%0d, want alarm=1 rise=0 avg=%0d",
                 i, alarm, alarm_rise, avg_out, m_avg);
      end
    end
    // Zeros: averages 30 then 26; the alarm clears on the second.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      n_checks++;
      if (alarm !== (i == 0) || avg_out !== WIDTH'(35 * (7 - i) / 8)) begin
        n_fail++;
        $display("FAIL alarm_down_%0d: got alarm=%0b avg=%0d, want alarm=%0b avg=%0d",
                 i, alarm, avg_out, i == 0, 35 * (7 - i) / 8);
      end
    end
  endtask

  task automatic test_peak_decay();
    int exp_peak[10] = '{100, 100, 100, 100, 100, 99, 98, 97, 96, 95};
    step(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, (i == 0) ? 100 : 10, 0);
      n_checks++;
      if (peak_out !== WIDTH'(exp_peak[i])) begin
        n_fail++;
        $display("FAIL peak_decay_%0d: got %0d, want %0d", i, peak_out, exp_peak[i]);
      end
    end
    step(1, 120, 0);
    n_checks++;
    if (peak_out !== 8'd120) begin
      n_fail++;
      $display("FAIL peak_new_max: got %0d, want 120", peak_out);
    end
  endtask

  task automatic test_gapped();
    logic [WIDTH-1:0] prev_avg, prev_peak;
    step(0, 0, 1);
    thr_hi = 8'd90;
    thr_lo = 8'd60;
    for (int i = 0; i < 24; i++) begin
      prev_avg  = avg_out;
      prev_peak = peak_out;
      if ($urandom_range(0, 1) == 1) begin
        step(0, int'($urandom_range(0, 255)), 0);
        n_checks++;
        if (out_valid !== 1'b0 || alarm_rise !== 1'b0 || avg_out !== prev_avg || peak_out !== prev_peak) begin
          n_fail++;
          $display("FAIL gap_%0d: got ov=%0b rise=%0b avg=%0d peak=%0d, want ov=0 rise=0 avg=%0d peak=%0d",
                   i, out_valid, alarm_rise, avg_out, peak_out, prev_avg, prev_peak);
        end
      end else begin
        step(1, int'($urandom_range(40, 160)), 0);
      end
      n_checks++;
      if ({avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid} !==
          {WIDTH'(m_avg), m_av, WIDTH'(m_peak), m_alarm, m_rise, m_ov}) begin
        n_fail++;
        $display("FAIL gapped_model_%0d: got avg=%0d av=%0b peak=%0d al=%0b r=%0b ov=%0b, want %0d %0b %0d %0b %0b %0b",
                 i, avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid,
                 m_avg, m_av, m_peak, m_alarm, m_rise, m_ov);
      end
    end
  endtask

  task automatic test_clear();
    step(0, 0, 1);
    thr_hi = 8'd10;
    thr_lo = 8'd5;
    for (int i = 0; i < 5; i++) step(1, 200, 0);
    step(1, 77, 1);
    n_checks++;
    if ({avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid} !== 20'h0) begin
      n_fail++;
      $display("FAIL clear_outputs: got avg=%0d av=%0b peak=%0d alarm=%0b rise=%0b ov=%0b, want all 0",
               avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid);
    end
    // The 77 must have been dropped: 8 fresh samples of 16 average to exactly 16.
    for (int i = 0; i < WIN; i++) begin
      step(1, 16, 0);
      n_checks++;
      if (avg_valid !== (i == WIN - 1) || avg_out !== WIDTH'(2 * (i + 1)) || alarm !== m_alarm) begin
        n_fail++;
        $display("FAIL clear_refill_%0d: got av=%0b avg=%0d alarm=%0b, want av=%0b avg=%0d alarm=%0b",
                 i, avg_valid, avg_out, alarm, i == WIN - 1, 2 * (i + 1), m_alarm);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1, 150, 0);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid} !== 20'h0) begin
      n_fail++;
      $display("FAIL async_reset: got avg=%0d av=%0b peak=%0d alarm=%0b rise=%0b ov=%0b, want all 0",
               avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit clr;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        thr_hi = WIDTH'($urandom_range(0, 255));
        thr_lo = WIDTH'($urandom_range(0, 255));
      end
      clr = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), clr);
      n_checks++;
      if ({avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid} !==
          {WIDTH'(m_avg), m_av, WIDTH'(m_peak), m_alarm, m_rise, m_ov}) begin
        n_fail++;
        $display("FAIL random_%0d: got avg=%0d av=%0b peak=%0d al=%0b r=%0b ov=%0b, want %0d %0b %0d %0b %0b %0b",
                 i, avg_out, avg_valid, peak_out, alarm, alarm_rise, out_valid,
                 m_avg, m_av, m_peak, m_alarm, m_rise, m_ov);
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_fill();
    test_alarm();
    test_peak_decay();
    test_gapped();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
